ballot_collector: RTL



---
 rtl/ballot_collector.sv | 104 ++++++++++
 1 files changed

// File: rtl/ballot_collector.sv
// ballot_collector: collects one weighted ballot per voter, closes on completion or timeout, then tallies serially into a majority result.
module ballot_collector #(
    parameter int N_VOTERS  = 6,
    parameter int THRESHOLD = 3,
    parameter int TIMEOUT   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                ballot_valid,
    output logic                ballot_ready,
    input  logic [2:0]          ballot_id,
    input  logic                ballot_vote,
    input  logic                ballot_double,
    output logic [N_VOTERS-1:0] votes_out,
    output logic [N_VOTERS-1:0] doubles_out,
    output logic [3:0]          tally,
    output logic                result,
    output logic                done,
    output logic                busy,
    output logic                dup_error,
    output logic                timeout_flag
);
    typedef enum logic [1:0] {IDLE, COLLECT, TALLY} state_t;
    state_t              state;
    logic [N_VOTERS-1:0] mask;
    logic [N_VOTERS-1:0] id_bit;
    logic [7:0]          timer;
    logic [2:0]          idx;
    logic                take;
    logic                accept;
    logic                complete;
    logic                expire;
    logic [3:0]          add;
    logic [3:0]          sum;
    // Out-of-range ids shift the one-hot bit off the end, so id_bit==0 marks them invalid.
    assign id_bit   = N_VOTERS'(1) << ballot_id;
    assign take     = ballot_valid && state == COLLECT;
    assign accept   = take && |id_bit && !(|(mask & id_bit));
    assign complete = accept && &(mask | id_bit);
    assign expire   = timer == 8'(TIMEOUT - 1);
    assign add      = votes_out[idx] ? (doubles_out[idx] ? 4'd2 : 4'd1) : 4'd0;
    assign sum      = tally + add;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mask         <= '0;
            timer        <= '0;
            idx          <= '0;
            votes_out    <= '0;
            doubles_out  <= '0;
            tally        <= '0;
            result       <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            ballot_ready <= 1'b0;
            dup_error    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            done      <= 1'b0;
            dup_error <= take && !accept;
            case (state)
                IDLE: if (start) begin
                    state        <= COLLECT;
                    ballot_ready <= 1'b1;
                    busy         <= 1'b1;
                    mask         <= '0;
                    timer        <= '0;
                    idx          <= '0;
                    votes_out    <= '0;
                    doubles_out  <= '0;
                    tally        <= '0;
                    result       <= 1'b0;
                    timeout_flag <= 1'b0;
                end
                COLLECT: begin
                    timer <= timer + 8'd1;
                    if (accept) begin
                        mask        <= mask | id_bit;
                        votes_out   <= ballot_vote ? votes_out | id_bit : votes_out & ~id_bit;
                        doubles_out <= ballot_double ? doubles_out | id_bit : doubles_out & ~id_bit;
                    end
                    if (complete || expire) begin
                        state        <= TALLY;
                        ballot_ready <= 1'b0;
                        idx          <= '0;
                        timeout_flag <= !complete;
                    end
                end
                TALLY: begin
                    tally <= sum;
                    idx   <= idx + 3'd1;
                    if (idx == 3'(N_VOTERS - 1)) begin
                        result <= sum >= 4'(THRESHOLD);
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
